// File: rtl/dmem_rmw_arbiter.sv
// dmem_rmw_arbiter: shares one single-port data memory between the MEM stage
// (A) and the loader/debug port (B).
// Byte/half stores become read-modify-write pairs; sub-word loads are
// extracted and sign/zero extended. Data and address buses number bit 0 as
// the MSB, so the byte offset is addr[30:31].
// Ports: clock, reset (async, active high);
//   x_req/x_we/x_size/x_signed/x_addr/x_wdata in,
//   x_rdata/x_done/x_stall out (x = a, b);
//   mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in; owner_b out.
// Optional: DMEM_ALIGN_CHECK_EN adds output align_err; misaligned
//   half/word accesses then complete without touching memory.
module dmem_rmw_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic              a_signed,
  input  logic [0:31]       a_addr,
  input  logic [0:31]       a_wdata,
  output logic [0:31]       a_rdata,
  output logic              a_done,
  output logic              a_stall,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_size,
  input  logic              b_signed,
  input  logic [0:31]       b_addr,
  input  logic [0:31]       b_wdata,
  output logic [0:31]       b_rdata,
  output logic              b_done,
  output logic              b_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [0:31]       mem_wdata,
  input  logic [0:31]       mem_rdata,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic              owner_b,
  output logic              align_err
`else
  output logic              owner_b
`endif
);

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [0:31] addr;
    logic [0:31] wdata;
  } req_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [1:0]  state_q, state_d;
  req_t        req_q, req_d;
  logic        owner_q, owner_d;
  logic [3:0]  wait_q, wait_d;
  logic [0:31] wr_q, wr_d;
  logic [0:31] a_rdata_q, a_rdata_d;
  logic [0:31] b_rdata_q, b_rdata_d;
  logic        mis_q, mis_d;

  req_t        a_in, b_in, win;
  logic        grant_a, grant_b;
  logic        win_mis;
  logic        done;
  logic        rd_upd;
  logic [0:31] cap_res;

  function automatic logic [0:31] load_fmt(
    input logic [0:31] rd,
    input req_t        r
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [0:31] res;
    unique case (r.addr[30:31])
      2'd0:    b = rd[0:7];
      2'd1:    b = rd[8:15];
      2'd2:    b = rd[16:23];
      default: b = rd[24:31];
    endcase
    h = r.addr[30] ? rd[16:31] : rd[0:15];
    unique case (1'b1)
      r.size[1]:         res = rd;
      r.size == 2'b01:   res = {{16{r.sgn & h[15]}}, h};
      default:           res = {{24{r.sgn & b[7]}}, b};
    endcase
    return res;
  endfunction

  // Only the addressed lane is replaced; the rest keeps the read value.
  function automatic logic [0:31] merge(
    input logic [0:31] rd,
    input req_t        r
  );
    logic [0:31] m;
    m = rd;
    unique case (1'b1)
      r.size[1]: m = r.wdata;
      r.size == 2'b01: begin
        if (r.addr[30]) m[16:31] = r.wdata[16:31];
        else            m[0:15]  = r.wdata[16:31];
      end
      default: begin
        unique case (r.addr[30:31])
          2'd0:    m[0:7]   = r.wdata[24:31];
          2'd1:    m[8:15]  = r.wdata[24:31];
          2'd2:    m[16:23] = r.wdata[24:31];
          default: m[24:31] = r.wdata[24:31];
        endcase
      end
    endcase
    return m;
  endfunction

  assign a_in = '{we: a_we, size: a_size, sgn: a_signed,
                  addr: a_addr, wdata: a_wdata};
  assign b_in = '{we: b_we, size: b_size, sgn: b_signed,
                  addr: b_addr, wdata: b_wdata};

  // B wins a tie only once it has lost MAX_WAIT arbitrations.
  always_comb begin
    grant_b = b_req & (~a_req | (wait_q == WAIT_MAX));
    grant_a = a_req & ~grant_b;
    win     = grant_b ? b_in : a_in;
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign win_mis = ((win.size == 2'b01) & win.addr[31])
                 | (win.size[1] & (win.addr[30:31] != 2'b00));
`else
  assign win_mis = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    owner_d   = owner_q;
    wait_d    = wait_q;
    wr_d      = wr_q;
    mis_d     = mis_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    done      = 1'b0;
    rd_upd    = 1'b0;
    cap_res   = load_fmt(mem_rdata, req_q);
    unique case (state_q)
      S_IDLE: begin
        if (grant_a | grant_b) begin
          req_d   = win;
          owner_d = grant_b;
          wr_d    = win.wdata;
          mis_d   = win_mis;
          if (grant_b)
            wait_d = 4'd0;
          else if (b_req && (wait_q != WAIT_MAX))
            wait_d = wait_q + 4'd1;
          unique case (1'b1)
            win_mis:               state_d = S_CAP;
            win.we & win.size[1]:  state_d = S_WR;
            default:               state_d = S_RD;
          endcase
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        unique case (1'b1)
          mis_q: begin
            done    = 1'b1;
            rd_upd  = 1'b1;
            cap_res = '0;
            state_d = S_IDLE;
          end
          req_q.we: begin
            wr_d    = merge(mem_rdata, req_q);
            state_d = S_WR;
          end
          default: begin
            done    = 1'b1;
            rd_upd  = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
      S_WR: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rd_upd) begin
      if (owner_q) b_rdata_d = cap_res;
      else         a_rdata_d = cap_res;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      owner_q   <= 1'b0;
      wait_q    <= 4'd0;
      wr_q      <= '0;
      mis_q     <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      owner_q   <= owner_d;
      wait_q    <= wait_d;
      wr_q      <= wr_d;
      mis_q     <= mis_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // rdata is live in the done cycle, then held by the flop.
  assign a_rdata   = a_rdata_d;
  assign b_rdata   = b_rdata_d;
  assign a_done    = done & ~owner_q;
  assign b_done    = done & owner_q;
  assign a_stall   = a_req & ~a_done;
  assign b_stall   = b_req & ~b_done;
  assign mem_en    = (state_q == S_RD) | (state_q == S_WR);
  assign mem_we    = (state_q == S_WR);
  assign mem_addr  = req_q.addr[30-ADDR_W:29];
  assign mem_wdata = wr_q;
  assign owner_b   = owner_q & (state_q != S_IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = done & mis_q;
`endif

  logic unused_addr;
  assign unused_addr = ^req_q.addr[0:29-ADDR_W];

endmodule

// File: tb/tb_dmem_rmw_arbiter.sv
// tb_dmem_rmw_arbiter: random and directed transactions on both ports
// against a word-array model of the memory and the arbitration rule.
module tb_dmem_rmw_arbiter;
  localparam int ADDR_W   = 8;
  localparam int MAX_WAIT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic a_req = 1'b0, b_req = 1'b0;
  logic a_we = 1'b0, b_we = 1'b0;
  logic a_signed = 1'b0, b_signed = 1'b0;
  logic [1:0] a_size = '0, b_size = '0;
  logic [31:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic [31:0] a_rdata, b_rdata;
  logic a_done, b_done, a_stall, b_stall;
  logic mem_en, mem_we, owner_b;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
  logic align_err;
`endif

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] last_rd [2];
  int errs = 0;
  int checks = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  dmem_rmw_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_size(a_size),
    .a_signed(a_signed), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_done(a_done), .a_stall(a_stall),
    .b_req(b_req), .b_we(b_we), .b_size(b_size),
    .b_signed(b_signed), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_done(b_done), .b_stall(b_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef DMEM_ALIGN_CHECK_EN
    .align_err(align_err),
`endif
    .owner_b(owner_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] w,
    input logic [1:0] sz, input bit sg, input logic [31:0] ad);
    int sh;
    logic [31:0] v;
    if (sz[1]) return w;
    if (sz == 2'b00) begin
      sh = 8 * (3 - int'(ad[1:0]));
      v = (w >> sh) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      sh = ad[1] ? 0 : 16;
      v = (w >> sh) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w,
    input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd);
    int sh;
    logic [31:0] mask;
    if (sz[1]) return wd;
    if (sz == 2'b00) begin
      sh = 8 * (3 - int'(ad[1:0]));
      mask = 32'hFF << sh;
    end else begin
      sh = ad[1] ? 0 : 16;
      mask = 32'hFFFF << sh;
    end
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  // Call at posedge+1 with the DUT idle; returns at posedge+1 after done.
  task automatic run_txn(input bit p, input bit we, input logic [1:0] sz,
    input bit sg, input logic [31:0] ad, input logic [31:0] wd,
    output logic [31:0] got);
    int cyc, n_en, n_we, exp_lat, exp_en;
    bit seen, mis, ae;
    logic [31:0] old, exp_v, wa_data;
    logic [ADDR_W-1:0] wi, wa;
    wi = ad[ADDR_W+1:2];
    old = ref_mem[wi];
    mis = 1'b0;
    ae = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (sz == 2'b01 && ad[0]) || (sz[1] && ad[1:0] != 2'b00);
`endif
    if (p) begin
      b_we = we; b_size = sz; b_signed = sg;
      b_addr = ad; b_wdata = wd; b_req = 1'b1;
    end else begin
      a_we = we; a_size = sz; a_signed = sg;
      a_addr = ad; a_wdata = wd; a_req = 1'b1;
    end
    cyc = 0; n_en = 0; n_we = 0; seen = 1'b0;
    got = '0; wa = '0; wa_data = '0;
    while (!seen && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (mem_en) n_en++;
      if (mem_en && mem_we) begin
        n_we++; wa = mem_addr; wa_data = mem_wdata;
      end
      if (cyc == 1) chk("stall_wait", p ? b_stall : a_stall, 1);
      if (p ? b_done : a_done) begin
        seen = 1'b1;
        got = p ? b_rdata : a_rdata;
        chk("stall_done", p ? b_stall : a_stall, 0);
        chk("owner_b", owner_b, p);
`ifdef DMEM_ALIGN_CHECK_EN
        ae = align_err;
`endif
      end
      @(posedge clock);
      #1;
    end
    if (p) b_req = 1'b0; else a_req = 1'b0;
    chk("done_seen", seen, 1);
    exp_lat = mis ? 2 : (we && sz[1]) ? 2 : we ? 4 : 3;
    exp_en  = mis ? 0 : (we && !sz[1]) ? 2 : 1;
    chk("latency", cyc, exp_lat);
    chk("mem_en_cycles", n_en, exp_en);
    chk("mem_we_cycles", n_we, (we && !mis) ? 1 : 0);
    chk("align_err", ae, mis);
    if (!we || mis) begin
      exp_v = mis ? 32'h0 : m_load(old, sz, sg, ad);
      chk("load_data", got, exp_v);
      last_rd[p] = exp_v;
    end else begin
      exp_v = m_merge(old, sz, ad, wd);
      chk("wr_addr", wa, wi);
      chk("wr_data", wa_data, exp_v);
      chk("rdata_hold", got, last_rd[p]);
      ref_mem[wi] = exp_v;
    end
  endtask

  initial begin
    logic [31:0] got;
    int n, cyc, nd, cnt;
    bit exp_b;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_b_done", b_done, 0);
    chk("rst_owner", owner_b, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_a_stall", a_stall, 0);
    reset = 1'b0;

    run_txn(0, 1, 2'b11, 0, 32'h10, 32'hDEAD_BEEF, got);
    run_txn(0, 0, 2'b11, 0, 32'h10, 32'h0, got);
    chk("dir_lw", got, 32'hDEAD_BEEF);
    run_txn(0, 1, 2'b11, 0, 32'h10, 32'h1122_3344, got);
    run_txn(0, 0, 2'b00, 1, 32'h12, 32'h0, got);
    chk("dir_lb_33", got, 32'h0000_0033);
    run_txn(0, 1, 2'b11, 0, 32'h10, 32'h11F2_3344, got);
    run_txn(0, 0, 2'b00, 1, 32'h11, 32'h0, got);
    chk("dir_lb_sx", got, 32'hFFFF_FFF2);
    run_txn(0, 0, 2'b00, 0, 32'h11, 32'h0, got);
    chk("dir_lbu", got, 32'h0000_00F2);
    run_txn(0, 1, 2'b11, 0, 32'h10, 32'h1122_3344, got);
    run_txn(0, 1, 2'b01, 0, 32'h12, 32'h0000_ABCD, got);
    run_txn(1, 0, 2'b10, 0, 32'h10, 32'h0, got);
    chk("dir_sh_merge", got, 32'h1122_ABCD);
    run_txn(1, 0, 2'b01, 1, 32'h13, 32'h0, got);

    for (int k = 0; k < 60; k++) begin
      bit rp, rw, rs;
      logic [1:0] rz;
      logic [31:0] ra, rd;
      rp = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      rz = 2'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 63));
      rd = $urandom;
      run_txn(rp, rw, rz, rs, ra, rd, got);
    end

    run_txn(0, 1, 2'b11, 0, 32'h20, 32'h1122_3344, got);
    a_we = 1'b1; a_size = 2'b01; a_signed = 1'b0;
    a_addr = 32'h22; a_wdata = 32'h0000_ABCD; a_req = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_seq_rd", mem_en, 1);
    @(posedge clock);
    #1;
    chk("rst_seq_cap", mem_en, 0);
    reset = 1'b1;
    #1;
    chk("rst_now_en", mem_en, 0);
    chk("rst_now_we", mem_we, 0);
    chk("rst_now_done", a_done, 0);
    chk("rst_now_wdata", mem_wdata, 0);
    chk("rst_now_addr", mem_addr, 0);
    chk("rst_now_rdata", a_rdata, 0);
    a_req = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clock);
      if (mem_we || a_done) n++;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (mem_we || a_done || mem_en) n++;
    end
    chk("rst_no_activity", n, 0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(posedge clock);
    #1;
    run_txn(0, 0, 2'b11, 0, 32'h20, 32'h0, got);
    chk("rst_mem_kept", got, 32'h1122_3344);

    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    a_we = 1'b0; a_size = 2'b11; a_addr = 32'h30;
    b_we = 1'b0; b_size = 2'b11; b_addr = 32'h34;
    a_req = 1'b1; b_req = 1'b1;
    cnt = 0; nd = 0; cyc = 0;
    while (nd < 10 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (a_done || b_done) begin
        exp_b = (cnt == MAX_WAIT);
        cnt = exp_b ? 0 : cnt + 1;
        chk("arb_b_done", b_done, exp_b);
        chk("arb_a_done", a_done, !exp_b);
        if (exp_b) chk("arb_b_data", b_rdata, ref_mem[13]);
        else       chk("arb_a_data", a_rdata, ref_mem[12]);
        nd++;
      end
      @(posedge clock);
    end
    #1;
    a_req = 1'b0; b_req = 1'b0;
    chk("arb_done_count", nd, 10);
    last_rd[0] = ref_mem[12];
    last_rd[1] = ref_mem[13];
    @(posedge clock);
    #1;

`ifdef DMEM_ALIGN_CHECK_EN
    run_txn(0, 0, 2'b11, 0, 32'h13, 32'h0, got);
    chk("al_word_rdata", got, 32'h0);
    run_txn(1, 1, 2'b01, 0, 32'h21, 32'hFFFF_FFFF, got);
    run_txn(1, 0, 2'b11, 0, 32'h20, 32'h0, got);
    chk("al_no_write", got, ref_mem[8]);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
